// File: rtl/alien_fleet_ctrl.sv
// rtl/alien_fleet_ctrl.sv - alien formation sequencer: march pacing, edge drop, shot scheduling, kills
module alien_fleet_ctrl #(
   parameter int ROWS        = 4,
   parameter int COLS        = 8,
   parameter int ALIEN_W     = 32,
   parameter int ALIEN_H     = 24,
   parameter int X_START     = 64,
   parameter int Y_START     = 48,
   parameter int X_MIN       = 16,
   parameter int X_MAX       = 624,
   parameter int Y_LIMIT     = 432,
   parameter int STEP_X      = 8,
   parameter int STEP_Y      = 16,
   parameter int MIN_PERIOD  = 4,
   parameter int FIRE_STRIDE = 3
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      frame_clk,
   input  logic                      start,
   input  logic                      kill_valid,
   input  logic [$clog2(ROWS)-1:0]   kill_row,
   input  logic [$clog2(COLS)-1:0]   kill_col,
   input  logic                      shot_busy,
   output logic [9:0]                grid_x,
   output logic [9:0]                grid_y,
   output logic [ROWS*COLS-1:0]      alive,
   output logic                      fire_req,
   output logic [9:0]                fire_x,
   output logic [9:0]                fire_y,
   output logic                      fleet_cleared,
   output logic                      fleet_landed
);
   localparam int N  = ROWS * COLS;
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   typedef enum logic [2:0] {IDLE, WAIT, SCAN, DECIDE, DROP, FIRE, DONE} state_t;
   state_t state, state_nxt;

   logic [1:0]    frame_sync;
   logic          frame_prev, tick;
   logic [7:0]    frame_cnt, pop, cnt_target, kill_idx, ptr_sum;
   logic [CW-1:0] fire_ptr, ptr_nxt, scan_col, left_col, right_col;
   logic          dir_right, scan_found, col_any, restart, cleared_now;
   logic [N-1:0]  snap, kill_mask;
   logic [RW-1:0] max_low, col_low;
   logic [COLS-1:0] col_alive;
   logic [RW-1:0] low_row [COLS];
   logic [9:0]    right_edge, left_edge, fire_x_calc, fire_y_calc, bottom_y;
   logic          drop_needed, landed;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_sync <= 2'b00;
         frame_prev <= 1'b0;
      end else begin
         frame_sync <= {frame_sync[0], frame_clk};
         frame_prev <= frame_sync[1];
      end
   end
   assign tick = frame_sync[1] & ~frame_prev;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++) pop = pop + 8'(alive[i]);
   end
   // fewer survivors -> shorter wait between marches
   assign cnt_target = 8'(MIN_PERIOD) + pop - 8'd1;

   assign kill_idx = 8'(kill_row) * 8'(COLS) + 8'(kill_col);
   always_comb begin
      kill_mask = '0;
      for (int i = 0; i < N; i++) kill_mask[i] = kill_valid && (kill_idx == 8'(i));
   end

   always_comb begin
      col_any = 1'b0;
      col_low = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (CW'(c) == scan_col && snap[r*COLS + c]) begin
               col_any = 1'b1;
               col_low = RW'(r);
            end
   end

   assign ptr_sum     = 8'(fire_ptr) + 8'(FIRE_STRIDE);
   assign ptr_nxt     = (ptr_sum >= 8'(COLS)) ? CW'(ptr_sum - 8'(COLS)) : CW'(ptr_sum);
   assign right_edge  = grid_x + (10'(right_col) + 10'd1) * 10'(ALIEN_W) + 10'(STEP_X);
   assign left_edge   = grid_x + 10'(left_col) * 10'(ALIEN_W);
   assign drop_needed = dir_right ? (right_edge > 10'(X_MAX)) : (left_edge < 10'(X_MIN + STEP_X));
   assign fire_x_calc = grid_x + 10'(ptr_nxt) * 10'(ALIEN_W) + 10'(ALIEN_W / 2);
   assign fire_y_calc = grid_y + (10'(low_row[ptr_nxt]) + 10'd1) * 10'(ALIEN_H);
   assign bottom_y    = grid_y + (10'(max_low) + 10'd1) * 10'(ALIEN_H);
   assign landed      = bottom_y >= 10'(Y_LIMIT);

   assign restart     = (state == IDLE || state == DONE) && start;
   assign cleared_now = (state != IDLE) && !restart && (alive == '0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = WAIT;
         WAIT:    if (tick && frame_cnt == cnt_target) state_nxt = SCAN;
         SCAN:    if (scan_col == CW'(COLS - 1)) state_nxt = DECIDE;
         DECIDE:  state_nxt = drop_needed ? DROP : FIRE;
         DROP:    state_nxt = FIRE;
         FIRE:    state_nxt = landed ? DONE : WAIT;
         DONE:    if (start) state_nxt = WAIT;
         default: state_nxt = IDLE;
      endcase
      if (cleared_now) state_nxt = DONE;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         alive         <= '0;
         grid_x        <= 10'(X_START);
         grid_y        <= 10'(Y_START);
         dir_right     <= 1'b1;
         frame_cnt     <= '0;
         fire_ptr      <= '0;
         fire_req      <= 1'b0;
         fire_x        <= '0;
         fire_y        <= '0;
         fleet_cleared <= 1'b0;
         fleet_landed  <= 1'b0;
         snap          <= '0;
         scan_col      <= '0;
         scan_found    <= 1'b0;
         left_col      <= '0;
         right_col     <= '0;
         max_low       <= '0;
         col_alive     <= '0;
         for (int c = 0; c < COLS; c++) low_row[c] <= '0;
      end else begin
         fire_req <= 1'b0;
         if (restart) begin
            alive         <= '1;
            grid_x        <= 10'(X_START);
            grid_y        <= 10'(Y_START);
            dir_right     <= 1'b1;
            frame_cnt     <= '0;
            fire_ptr      <= '0;
            fleet_cleared <= 1'b0;
            fleet_landed  <= 1'b0;
         end else begin
            if (state != IDLE) alive <= alive & ~kill_mask;
            if (cleared_now) begin
               fleet_cleared <= 1'b1;
            end else begin
               case (state)
                  WAIT: if (tick) begin
                     if (frame_cnt == cnt_target) begin
                        frame_cnt  <= '0;
                        snap       <= alive;
                        scan_col   <= '0;
                        scan_found <= 1'b0;
                        max_low    <= '0;
                     end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                     end
                  end
                  SCAN: begin
                     col_alive[scan_col] <= col_any;
                     low_row[scan_col]   <= col_low;
                     if (col_any) begin
                        if (!scan_found) left_col <= scan_col;
                        scan_found <= 1'b1;
                        right_col  <= scan_col;
                        if (col_low > max_low) max_low <= col_low;
                     end
                     scan_col <= scan_col + CW'(1);
                  end
                  DECIDE: if (!drop_needed)
                     grid_x <= dir_right ? grid_x + 10'(STEP_X) : grid_x - 10'(STEP_X);
                  DROP: begin
                     grid_y    <= grid_y + 10'(STEP_Y);
                     dir_right <= ~dir_right;
                  end
                  FIRE: begin
                     fire_ptr <= ptr_nxt;
                     if (!shot_busy && col_alive[ptr_nxt]) begin
                        fire_req <= 1'b1;
                        fire_x   <= fire_x_calc;
                        fire_y   <= fire_y_calc;
                     end
                     if (landed) fleet_landed <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// tb/tb_alien_fleet_ctrl.sv - directed self-checking bench for alien_fleet_ctrl
module tb_alien_fleet_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_clk = 1'b0;
   logic        start = 1'b0;
   logic        kill_valid = 1'b0;
   logic [1:0]  kill_row = '0;
   logic [2:0]  kill_col = '0;
   logic        shot_busy = 1'b0;

   logic [9:0]  grid_x, grid_y, fire_x, fire_y;
   logic [31:0] alive;
   logic        fire_req, fleet_cleared, fleet_landed;

   logic [9:0]  l_grid_x, l_grid_y, l_fire_x, l_fire_y;
   logic [31:0] l_alive;
   logic        l_fire_req, l_fleet_cleared, l_fleet_landed;

   int checks = 0;
   int errors = 0;
   int fire_cnt = 0;
   logic [9:0] last_fx = '0, last_fy = '0;

   always #5 clk = ~clk;

   alien_fleet_ctrl u_dut (
      .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .start(start),
      .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col), .shot_busy(shot_busy),
      .grid_x(grid_x), .grid_y(grid_y), .alive(alive), .fire_req(fire_req),
      .fire_x(fire_x), .fire_y(fire_y), .fleet_cleared(fleet_cleared), .fleet_landed(fleet_landed)
   );

   // low landing line so the first drop lands the fleet
   alien_fleet_ctrl #(.Y_LIMIT(160)) u_land (
      .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .start(start),
      .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col), .shot_busy(shot_busy),
      .grid_x(l_grid_x), .grid_y(l_grid_y), .alive(l_alive), .fire_req(l_fire_req),
      .fire_x(l_fire_x), .fire_y(l_fire_y), .fleet_cleared(l_fleet_cleared), .fleet_landed(l_fleet_landed)
   );

   always @(negedge clk) begin
      if (fire_req) begin
         fire_cnt = fire_cnt + 1;
         last_fx  = fire_x;
         last_fy  = fire_y;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_clk = 1'b1;
      cyc(3);
      frame_clk = 1'b0;
      cyc(3);
   endtask

   task automatic march(input int nticks);
      repeat (nticks) tick();
      cyc(14);
   endtask

   task automatic kill(input int r, input int c);
      kill_row   = 2'(r);
      kill_col   = 3'(c);
      kill_valid = 1'b1;
      cyc(1);
      kill_valid = 1'b0;
      cyc(1);
   endtask

   task automatic do_reset_start();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(1);
   endtask

   initial begin
      int n;
      int f0;

      cyc(2);
      chk("rst_grid_x", 64'(grid_x), 64'd64);
      chk("rst_grid_y", 64'(grid_y), 64'd48);
      chk("rst_alive", 64'(alive), 64'd0);
      chk("rst_fire_req", 64'(fire_req), 64'd0);
      chk("rst_fire_xy", 64'({fire_x, fire_y}), 64'd0);
      chk("rst_flags", 64'({fleet_cleared, fleet_landed}), 64'd0);
      rst_n = 1'b1;
      cyc(2);

      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(1);
      chk("start_alive", 64'(alive), 64'hFFFF_FFFF);

      // full fleet: 36 ticks per march
      f0 = fire_cnt;
      repeat (35) tick();
      cyc(14);
      chk("m1_35ticks_grid_x", 64'(grid_x), 64'd64);
      chk("m1_35ticks_nofire", 64'(fire_cnt - f0), 64'd0);
      frame_clk = 1'b1;
      n = 0;
      while (grid_x == 10'd64 && n < 30) begin
         cyc(1);
         n++;
      end
      frame_clk = 1'b0;
      chk("m1_latency_ok", 64'(n <= 13), 64'd1);
      chk("m1_grid_x", 64'(grid_x), 64'd72);
      cyc(8);
      chk("m1_fire_cnt", 64'(fire_cnt - f0), 64'd1);
      chk("m1_fire_x", 64'(last_fx), 64'd184);
      chk("m1_fire_y", 64'(last_fy), 64'd144);

      for (int m = 2; m <= 38; m++) march(36);
      chk("m38_grid_x", 64'(grid_x), 64'd368);
      chk("m38_grid_y", 64'(grid_y), 64'd48);
      chk("m38_land_not_landed", 64'(l_fleet_landed), 64'd0);

      march(36);
      chk("m39_drop_grid_x", 64'(grid_x), 64'd368);
      chk("m39_drop_grid_y", 64'(grid_y), 64'd64);
      chk("m39_not_landed", 64'(fleet_landed), 64'd0);
      chk("m39_land_grid_y", 64'(l_grid_y), 64'd64);
      chk("m39_land_landed", 64'(l_fleet_landed), 64'd1);

      march(36);
      chk("m40_left_grid_x", 64'(grid_x), 64'd360);
      chk("m40_grid_y", 64'(grid_y), 64'd64);

      // async reset while the march scan is in progress
      repeat (35) tick();
      frame_clk = 1'b1;
      cyc(5);
      frame_clk = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midscan_rst_grid_x", 64'(grid_x), 64'd64);
      chk("midscan_rst_grid_y", 64'(grid_y), 64'd48);
      chk("midscan_rst_alive", 64'(alive), 64'd0);
      chk("midscan_rst_fire_xy", 64'({fire_x, fire_y}), 64'd0);
      chk("midscan_rst_land_flag", 64'(l_fleet_landed), 64'd0);
      cyc(2);

      // kill (3,3) before march 1; period shortens to 35 ticks
      do_reset_start();
      kill(3, 3);
      chk("kill33_alive", 64'(alive), 64'hF7FF_FFFF);
      kill(3, 3);
      chk("kill33_repeat_alive", 64'(alive), 64'hF7FF_FFFF);
      f0 = fire_cnt;
      march(34);
      chk("kill_34ticks_grid_x", 64'(grid_x), 64'd64);
      march(1);
      chk("kill_35ticks_grid_x", 64'(grid_x), 64'd72);
      chk("kill_fire_cnt", 64'(fire_cnt - f0), 64'd1);
      chk("kill_fire_x", 64'(last_fx), 64'd184);
      chk("kill_fire_y", 64'(last_fy), 64'd120);

      // busy across march 1, column 6 fires on march 2
      do_reset_start();
      f0 = fire_cnt;
      shot_busy = 1'b1;
      march(36);
      shot_busy = 1'b0;
      chk("busy_nofire", 64'(fire_cnt - f0), 64'd0);
      chk("busy_grid_x", 64'(grid_x), 64'd72);
      march(36);
      chk("col6_fire_cnt", 64'(fire_cnt - f0), 64'd1);
      chk("col6_fire_x", 64'(last_fx), 64'd288);
      chk("col6_fire_y", 64'(last_fy), 64'd144);

      // kill the whole fleet
      f0 = fire_cnt;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++) begin
            kill_row   = 2'(r);
            kill_col   = 3'(c);
            kill_valid = 1'b1;
            cyc(1);
         end
      kill_valid = 1'b0;
      chk("allkill_alive", 64'(alive), 64'd0);
      cyc(1);
      chk("allkill_cleared", 64'(fleet_cleared), 64'd1);
      chk("allkill_not_landed", 64'(fleet_landed), 64'd0);
      cyc(3);
      chk("allkill_nofire", 64'(fire_cnt - f0), 64'd0);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("restart_alive", 64'(alive), 64'hFFFF_FFFF);
      chk("restart_cleared", 64'(fleet_cleared), 64'd0);
      chk("restart_grid", 64'({grid_x, grid_y}), 64'({10'd64, 10'd48}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
